// File: rtl/audio_rec_ctrl.sv
// Recorder/player control for the lab3 audio system: sequences SRAM sample
// addresses for recording and variable-speed playback from debounced keys.
module audio_rec_ctrl #(
  parameter int unsigned            ADDR_W   = 20,
  parameter logic [ADDR_W-1:0]      ADDR_MAX = 20'hFFFFF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_init_done,
  input  logic              i_key_rec,
  input  logic              i_key_play,
  input  logic              i_key_stop,
  input  logic              i_sample_tick,
  input  logic [17:0]       i_sw,
  output logic [2:0]        o_state,
  output logic [ADDR_W-1:0] o_addr,
  output logic [ADDR_W-1:0] o_rec_end,
  output logic              o_sram_we
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HOLD  = 3'd1,
    S_REC   = 3'd2,
    S_PLAY  = 3'd3,
    S_PAUSE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_d, rec_end_d;
  logic                we_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [3:0]          speed_n;
  logic [ADDR_W:0]     step;
  logic [ADDR_W:0]     addr_next;
  logic                advance;
  logic                unused_sw;

  assign unused_sw = ^{i_sw[16:9], i_sw[1:0]};
  assign o_state   = state_q;

  // Highest set switch among 8..2 selects the speed factor; none selects 1.
  always_comb begin
    speed_n = 4'd1;
    for (int unsigned i = 2; i <= 8; i++) begin
      if (i_sw[i]) speed_n = 4'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = o_addr;
    rec_end_d = o_rec_end;
    we_d      = 1'b0;
    cnt_d     = cnt_q;
    step      = '0;
    advance   = 1'b0;
    addr_next = {1'b0, o_addr};

    case (state_q)
      S_IDLE: begin
        if (i_init_done) state_d = S_HOLD;
      end

      S_HOLD: begin
        addr_d = '0;
        if (i_key_stop) begin
          state_d = S_HOLD;
        end else if (i_key_rec) begin
          state_d = S_REC;
        end else if (i_key_play && (o_rec_end != '0)) begin
          state_d = S_PLAY;
          cnt_d   = '0;
        end
      end

      S_REC: begin
        // A strobe already on the bus always completes, even alongside stop.
        if (o_sram_we) begin
          if (o_addr == ADDR_MAX) begin
            rec_end_d = ADDR_MAX;
            addr_d    = '0;
            state_d   = S_HOLD;
          end else begin
            addr_d = o_addr + 1'b1;
          end
        end
        if (!(o_sram_we && (o_addr == ADDR_MAX))) begin
          if (i_key_stop) begin
            rec_end_d = addr_d;
            addr_d    = '0;
            state_d   = S_HOLD;
          end else if (i_sample_tick) begin
            we_d = 1'b1;
          end
        end
      end

      S_PLAY: begin
        if (i_key_stop) begin
          state_d = S_HOLD;
          addr_d  = '0;
        end else if (i_key_play) begin
          state_d = S_PAUSE;
        end else if (i_sample_tick) begin
          if (i_sw[17]) begin
            step    = (ADDR_W+1)'(speed_n);
            advance = 1'b1;
          end else if ({1'b0, cnt_q} >= (speed_n - 4'd1)) begin
            step    = (ADDR_W+1)'(1);
            advance = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
          addr_next = {1'b0, o_addr} + step;
          if (advance) begin
            if (addr_next >= {1'b0, o_rec_end}) begin
              state_d = S_HOLD;
              addr_d  = '0;
            end else begin
              addr_d = addr_next[ADDR_W-1:0];
            end
          end
        end
      end

      S_PAUSE: begin
        if (i_key_stop) begin
          state_d = S_HOLD;
          addr_d  = '0;
        end else if (i_key_play) begin
          state_d = S_PLAY;
        end
      end

      default: begin
        state_d = S_HOLD;
        addr_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      o_addr    <= '0;
      o_rec_end <= '0;
      o_sram_we <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      o_addr    <= addr_d;
      o_rec_end <= rec_end_d;
      o_sram_we <= we_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_audio_rec_ctrl.sv
// Self-checking bench for audio_rec_ctrl: directed scenarios plus a random
// phase, all compared cycle by cycle against a behavioural recorder model.
module tb_audio_rec_ctrl;

  localparam int AMAX = 'hFFFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        init_done = 1'b0;
  logic        key_rec = 1'b0, key_play = 1'b0, key_stop = 1'b0, tick = 1'b0;
  logic [17:0] sw = '0;
  logic [2:0]  state;
  logic [19:0] addr, rec_end;
  logic        we;

  int total = 0;
  int bad   = 0;

  int m_state = 0, m_addr = 0, m_rec_end = 0, m_cnt = 0;
  bit m_we = 1'b0;
  int wlog[$];

  audio_rec_ctrl #(.ADDR_W(20), .ADDR_MAX(20'hFFFFF)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_init_done(init_done),
    .i_key_rec(key_rec), .i_key_play(key_play), .i_key_stop(key_stop),
    .i_sample_tick(tick), .i_sw(sw),
    .o_state(state), .o_addr(addr), .o_rec_end(rec_end), .o_sram_we(we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int speed_of(input logic [17:0] s);
    for (int i = 8; i >= 2; i--) if (s[i]) return i;
    return 1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_addr = 0; m_rec_end = 0; m_cnt = 0; m_we = 1'b0;
  endtask

  // Recorder behaviour expressed with plain integers, evaluated at each edge.
  task automatic model_edge();
    int n, stp;
    bit pend;
    if (!rst_n) begin model_reset(); return; end
    n = speed_of(sw);
    pend = m_we;
    m_we = 1'b0;
    case (m_state)
      0: if (init_done) m_state = 1;
      1: begin
        if (key_stop) m_state = 1;
        else if (key_rec) m_state = 2;
        else if (key_play && m_rec_end != 0) begin m_state = 3; m_cnt = 0; end
      end
      2: begin
        if (pend) begin
          if (m_addr == AMAX) begin m_rec_end = AMAX; m_addr = 0; m_state = 1; end
          else m_addr = m_addr + 1;
        end
        if (m_state == 2) begin
          if (key_stop) begin m_rec_end = m_addr; m_addr = 0; m_state = 1; end
          else if (tick) m_we = 1'b1;
        end
      end
      3: begin
        if (key_stop) begin m_state = 1; m_addr = 0; end
        else if (key_play) m_state = 4;
        else if (tick) begin
          stp = 0;
          if (sw[17]) stp = n;
          else if (m_cnt >= n - 1) begin stp = 1; m_cnt = 0; end
          else m_cnt = m_cnt + 1;
          if (stp != 0) begin
            if (m_addr + stp >= m_rec_end) begin m_state = 1; m_addr = 0; end
            else m_addr = m_addr + stp;
          end
        end
      end
      4: begin
        if (key_stop) begin m_state = 1; m_addr = 0; end
        else if (key_play) m_state = 3;
      end
      default: m_state = 1;
    endcase
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("state",   32'(state),   32'(m_state));
    chk("addr",    32'(addr),    32'(m_addr));
    chk("rec_end", 32'(rec_end), 32'(m_rec_end));
    chk("we",      32'(we),      32'(m_we));
    if (we) wlog.push_back(int'(addr));
    key_rec = 1'b0; key_play = 1'b0; key_stop = 1'b0; tick = 1'b0;
  endtask

  task automatic ticks(input int count, input int gap);
    for (int k = 0; k < count; k++) begin
      tick = 1'b1;
      cyc();
      repeat (gap) cyc();
    end
  endtask

  initial begin
    // Reset behaviour and IDLE key immunity
    #1 rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_rec_end", 32'(rec_end), 0);
    chk("rst_we", 32'(we), 0);
    repeat (3) begin key_rec = 1'b1; tick = 1'b1; cyc(); end
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      key_rec = (k == 2); key_play = (k == 5); key_stop = (k == 7);
      cyc();
      chk("idle_state", 32'(state), 0);
    end
    init_done = 1'b1;
    cyc();
    chk("hold_after_init", 32'(state), 1);

    // Five-sample recording then stop
    wlog.delete();
    key_rec = 1'b1; cyc();
    chk("rec_entry", 32'(state), 2);
    ticks(5, 3);
    key_stop = 1'b1; cyc();
    chk("wr_count", 32'(wlog.size()), 5);
    for (int i = 0; i < wlog.size() && i < 5; i++) chk("wr_addr", 32'(wlog[i]), 32'(i));
    chk("rec_end5", 32'(rec_end), 5);
    chk("hold_after_stop", 32'(state), 1);
    chk("addr_after_stop", 32'(addr), 0);

    // 100-sample recording, fast play N=4
    key_rec = 1'b1; cyc();
    ticks(100, 2);
    key_stop = 1'b1; cyc();
    chk("rec_end100", 32'(rec_end), 100);
    sw = '0; sw[17] = 1'b1; sw[4] = 1'b1;
    key_play = 1'b1; cyc();
    chk("play_entry", 32'(state), 3);
    for (int k = 1; k <= 25; k++) begin
      tick = 1'b1; cyc();
      if (k < 25) chk("fast_addr", 32'(addr), 32'(4 * k));
      else begin
        chk("fast_end_state", 32'(state), 1);
        chk("fast_end_addr", 32'(addr), 0);
      end
      cyc();
    end

    // Slow play N=3 with pause and resume
    sw = '0; sw[3] = 1'b1;
    key_play = 1'b1; cyc();
    ticks(9, 2);
    chk("slow_addr3", 32'(addr), 3);
    key_play = 1'b1; cyc();
    chk("pause_state", 32'(state), 4);
    ticks(5, 2);
    chk("pause_addr", 32'(addr), 3);
    key_play = 1'b1; cyc();
    chk("resume_state", 32'(state), 3);
    ticks(3, 2);
    chk("slow_addr4", 32'(addr), 4);

    // Same-cycle key and tick interactions
    tick = 1'b1; key_play = 1'b1; cyc();
    chk("tick_key_pause", 32'(state), 4);
    chk("tick_key_addr", 32'(addr), 4);
    key_play = 1'b1; cyc();
    key_play = 1'b1; key_stop = 1'b1; cyc();
    chk("play_stop_hold", 32'(state), 1);
    key_rec = 1'b1; key_stop = 1'b1; cyc();
    chk("rec_stop_hold", 32'(state), 1);

    // Recording that runs into the last address
    key_rec = 1'b1; cyc();
    cyc();
    force dut.o_addr = 20'hFFFFD;
    #1 release dut.o_addr;
    m_addr = 'hFFFFD;
    wlog.delete();
    ticks(3, 3);
    chk("max_wr_count", 32'(wlog.size()), 3);
    for (int i = 0; i < wlog.size() && i < 3; i++) chk("max_wr_addr", 32'(wlog[i]), 32'('hFFFFD + i));
    chk("max_state", 32'(state), 1);
    chk("max_rec_end", 32'(rec_end), 32'hFFFFF);

    // Asynchronous reset in the middle of playback
    sw = '0; sw[17] = 1'b1; sw[8] = 1'b1;
    key_play = 1'b1; cyc();
    ticks(4, 1);
    chk("pre_reset_addr", 32'(addr), 32);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 0);
    chk("arst_addr", 32'(addr), 0);
    chk("arst_rec_end", 32'(rec_end), 0);
    chk("arst_we", 32'(we), 0);
    model_reset();
    #2 rst_n = 1'b1;
    cyc();
    chk("reinit_hold", 32'(state), 1);
    key_play = 1'b1; cyc();
    chk("play_no_rec", 32'(state), 1);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      int r;
      if (m_state == 1 && $urandom_range(0, 7) == 0) sw = 18'($urandom);
      r = int'($urandom_range(0, 39));
      key_rec  = (r == 0);
      key_play = (r == 1) || (r == 2 && m_state != 2);
      key_stop = (r == 3);
      tick     = (r >= 4) && ($urandom_range(0, 2) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_rec_ctrl.md
# audio_rec_ctrl

Recorder/player control FSM for the lab3 audio system. Consumes debounced key pulses, speed switches and the codec sample tick; produces the 3-bit state code, the 20-bit SRAM sample address and the SRAM write strobe. Sits directly upstream of the seven-segment display stage, which decodes `o_state`, `o_addr` and `i_sw`, and alongside the SRAM/codec datapath, which uses `o_addr`/`o_sram_we`.

## Interface
- `ADDR_W`, default 20: SRAM word-address width.
- `ADDR_MAX`, default 20'hFFFFF: last writable address.
- `i_clk`  in  1  system clock; one clock domain, all logic rising-edge.
- `i_rst_n`  in  1  reset, asynchronous assert, active-low.
- `i_init_done`  in  1  level; codec initialisation finished.
- `i_key_rec`  in  1  one-cycle pulse; start recording.
- `i_key_play`  in  1  one-cycle pulse; play, or toggle pause.
- `i_key_stop`  in  1  one-cycle pulse; stop.
- `i_sample_tick`  in  1  one-cycle pulse per codec sample (LRCK rate).
- `i_sw`  in  18  switches; bit 17 = fast(1)/slow(0), bits 8..2 = speed factor.
- `o_state`  out  3  0 IDLE, 1 HOLD, 2 REC, 3 PLAY, 4 PAUSE.
- `o_addr`  out  ADDR_W  current SRAM sample address.
- `o_rec_end`  out  ADDR_W  address one past last recorded sample.
- `o_sram_we`  out  1  one-cycle write strobe, valid with `o_addr`.

## Operation
- Speed factor N: highest set bit among `i_sw[8:2]` gives N = 8..2, none set gives N = 1. Sampled on every tick; a change takes effect at the next tick.
- IDLE: keys ignored; to HOLD on the first cycle `i_init_done` = 1.
- HOLD: `o_addr` = 0.
  - rec -> REC, `o_addr` = 0.
  - play -> PLAY if `o_rec_end` != 0; else ignored.
- REC, on each tick:
  - strobe `o_sram_we` with current address A;
  - next cycle `o_addr` = A+1.
  - After the write at ADDR_MAX: `o_rec_end` = ADDR_MAX+1 truncated to ADDR_MAX, then go HOLD.
  - stop -> HOLD, `o_rec_end` = `o_addr` (a pending strobe still completes first).
  - play is ignored.
- PLAY, fast (sw17 = 1): each tick, `o_addr` += N.
- PLAY, slow (sw17 = 0):
  - hold counter increments per tick;
  - when counter >= N-1, `o_addr` += 1 and counter clears;
  - counter clears on PLAY entry.
- PLAY end: if the next address >= `o_rec_end` -> HOLD, `o_addr` = 0 (no wrap).
- PLAY key transitions: play -> PAUSE; stop -> HOLD, addr 0; rec ignored.
- PAUSE: address and counter frozen, ticks ignored; play -> PLAY (counter kept); stop -> HOLD, addr 0; rec ignored.
- Simultaneous keys: stop > rec > play. Key on the same cycle as a tick: the key wins; that tick's advance/write is dropped, except an already-pending write strobe.
- Address arithmetic is ADDR_W+1 bits wide for the end compare; `o_addr` never exceeds ADDR_MAX.
- Undefined state codes (5-7) recover to HOLD on the next clock.

## Timing
- All outputs registered.
- Reset values: `o_state` = 0, `o_addr` = 0, `o_rec_end` = 0, `o_sram_we` = 0, hold counter 0.
- Reset mid-operation: immediate async return to reset values; the recording is forgotten (`o_rec_end` = 0).
- Key pulse at cycle t -> `o_state` updated at t+1.
- REC tick at t -> `o_sram_we` = 1 at t+1 with `o_addr` = A -> `o_addr` = A+1, `o_sram_we` = 0 at t+2.
- PLAY tick at t -> new `o_addr` at t+1.
- `i_init_done` high at t -> HOLD at t+1.

## Test plan
- Reset, `i_init_done` = 0 for 10 cycles then 1; keys pulsed during IDLE -> state stays 0, then 1 one cycle after init; all outputs 0 during reset.
- HOLD, rec, 5 ticks, stop -> exactly 5 `o_sram_we` strobes at addresses 0..4; `o_rec_end` = 5; state 1; `o_addr` = 0.
- `o_rec_end` = 100; play with sw17 = 1, sw4 = 1 (N = 4); 25 ticks -> `o_addr` 4, 8, …, 96, then HOLD with `o_addr` = 0 on the 25th tick.
- Slow play with sw3 = 1 (N = 3); 9 ticks -> `o_addr` = 3; play (PAUSE), 5 ticks -> `o_addr` stays 3; play -> resumes, 3 more ticks -> 4.
- Same-cycle pulses: rec+stop in HOLD -> stays HOLD; play+stop in PLAY -> HOLD. Play with `o_rec_end` = 0 -> stays HOLD.
- Preload recording near ADDR_MAX (force `o_addr` = 20'hFFFFD); 3 ticks -> writes FFFFD..FFFFF, then HOLD with `o_rec_end` = FFFFF. Assert `i_rst_n` mid-PLAY -> all outputs 0 asynchronously.
